tick_generator: RTL and testbench

//  Parametrised periodic tick source for game/animation timing logic.
//  - Emits a one-cycle `tick` every P(active_speed) cycles.
//  - Speed changes use a valid/ready handshake and apply only on a period boundary.
//  - Has a run/idle enable.
//  - Replaces fixed four-speed hard-coded dividers.

---
 rtl/tick_gen_pkg.sv | 19 +
 rtl/tick_gen_period_cnt.sv | 31 +++
 rtl/tick_generator.sv | 155 +++++++++++++++
 tb/tb_tick_generator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Tick generator shared types and period helper.
// Exports the IDLE/RUN state type and period_of() used by tick_generator.
package tick_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tick_gen_state_e;

   // Period length in cycles for a given speed level.
   function automatic int unsigned period_of(
      input int unsigned speed,
      input int unsigned base_period,
      input int unsigned step
   );
      return base_period - speed * step;
   endfunction

endpackage

// File: rtl/tick_gen_period_cnt.sv
// Period counter for the tick generator.
// Ports: Clock, Reset, clear (force 0), run (count), terminal (last
// count value), wrap (high when this edge returns the count to 0).
module tick_gen_period_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             clear,
   input  logic             run,
   input  logic [CNT_W-1:0] terminal,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt;

   assign wrap = run && !clear && (cnt == terminal);

   always_ff @(posedge Clock) begin
      if (Reset || clear) begin
         cnt <= '0;
      end else if (run) begin
         if (wrap) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/tick_generator.sv
// Periodic tick source with handshaked speed changes on period boundaries.
// Ports: Clock, Reset (sync, active-high), enable, speed/speed_valid/
// speed_ready request channel, tick, active_speed, busy, and tick_count
// when built with TICK_GEN_COUNT_EN (width COUNT_W, wraps, Reset-only clear).
module tick_generator #(
   parameter int CNT_W       = 16,
   parameter int SPEED_W     = 2,
   parameter int BASE_PERIOD = 30000,
   parameter int STEP        = 5000,
   parameter int RESET_SPEED = 0
`ifdef TICK_GEN_COUNT_EN
   ,
   parameter int COUNT_W     = 16
`endif
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               enable,
   input  logic [SPEED_W-1:0] speed,
   input  logic               speed_valid,
   output logic               speed_ready,
   output logic               tick,
   output logic [SPEED_W-1:0] active_speed,
`ifdef TICK_GEN_COUNT_EN
   output logic               busy,
   output logic [COUNT_W-1:0] tick_count
`else
   output logic               busy
`endif
);

   import tick_gen_pkg::*;

   if ((BASE_PERIOD - ((1 << SPEED_W) - 1) * STEP) < 2) begin : g_bad_step
      $error("tick_generator: slowest-to-fastest period drops below 2");
   end

   if (longint'(BASE_PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
      $error("tick_generator: CNT_W too narrow for BASE_PERIOD");
   end

   if (RESET_SPEED >= (1 << SPEED_W)) begin : g_bad_rst_spd
      $error("tick_generator: RESET_SPEED out of range");
   end

   tick_gen_state_e state;
   tick_gen_state_e next_state;

   logic               clear;
   logic               run;
   logic               wrap;
   logic               accept;
   logic               apply;
   logic               pending_valid;
   logic [SPEED_W-1:0] pending_speed;
   logic [CNT_W-1:0]   period;
   logic [CNT_W-1:0]   terminal;

   // Truncation to CNT_W lets BASE_PERIOD == 2**CNT_W map to
   // a terminal count of all ones.
   assign period   = CNT_W'(period_of(32'(active_speed),
                                      BASE_PERIOD, STEP));
   assign terminal = period - CNT_W'(1);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (enable) next_state = RUN;
         RUN:  if (!enable) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // clear is high in IDLE and on the RUN->IDLE edge.
   always_comb begin
      busy  = 1'b0;
      run   = 1'b0;
      clear = 1'b1;
      unique case (state)
         IDLE: begin
            busy  = 1'b0;
            run   = 1'b0;
            clear = 1'b1;
         end
         RUN: begin
            busy  = 1'b1;
            run   = enable;
            clear = !enable;
         end
         default: begin
            busy  = 1'b0;
            run   = 1'b0;
            clear = 1'b1;
         end
      endcase
   end

   tick_gen_period_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .Clock    (Clock),
      .Reset    (Reset),
      .clear    (clear),
      .run      (run),
      .terminal (terminal),
      .wrap     (wrap)
   );

   assign speed_ready = !pending_valid;
   assign accept      = speed_valid && speed_ready;
   // A pending change lands at a period boundary: any edge while
   // idle, a wrap, or the stop edge.
   assign apply       = pending_valid && (clear || wrap);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pending_valid <= 1'b0;
         pending_speed <= '0;
         active_speed  <= SPEED_W'(RESET_SPEED);
      end else if (accept) begin
         pending_valid <= 1'b1;
         pending_speed <= speed;
      end else if (apply) begin
         pending_valid <= 1'b0;
         active_speed  <= pending_speed;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tick <= 1'b0;
      end else begin
         tick <= wrap;
      end
   end

`ifdef TICK_GEN_COUNT_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tick_count <= '0;
      end else if (wrap) begin
         tick_count <= tick_count + COUNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with BASE_PERIOD=10, STEP=2
// (periods 10,8,6,4), SPEED_W=2; COUNT_W=2 when TICK_GEN_COUNT_EN.
module tb_tick_generator;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] speed = 2'd0;
   logic       speed_valid = 1'b0;
   logic       speed_ready;
   logic       tick;
   logic [1:0] active_speed;
   logic       busy;
`ifdef TICK_GEN_COUNT_EN
   logic [1:0] tick_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;
   int exp_ticks[$];

   typedef struct {
      logic       rst;
      logic       en;
      logic       vld;
      logic [1:0] spd;
      logic       tk;
      logic       rdy;
      logic       bsy;
      logic [1:0] act;
   } vec_t;

   vec_t tbl[8];

   always #5 Clock = ~Clock;

   tick_generator #(
      .CNT_W       (16),
      .SPEED_W     (2),
      .BASE_PERIOD (10),
      .STEP        (2),
      .RESET_SPEED (0)
`ifdef TICK_GEN_COUNT_EN
      ,
      .COUNT_W     (2)
`endif
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .enable       (enable),
      .speed        (speed),
      .speed_valid  (speed_valid),
      .speed_ready  (speed_ready),
      .tick         (tick),
      .active_speed (active_speed),
`ifdef TICK_GEN_COUNT_EN
      .busy         (busy),
      .tick_count   (tick_count)
`else
      .busy         (busy)
`endif
   );

   function automatic vec_t mk(input int rst, input int en,
                               input int vld, input int spd,
                               input int tk, input int rdy,
                               input int bsy, input int act);
      vec_t r;
      r.rst = rst[0];
      r.en  = en[0];
      r.vld = vld[0];
      r.spd = spd[1:0];
      r.tk  = tk[0];
      r.rdy = rdy[0];
      r.bsy = bsy[0];
      r.act = act[1:0];
      return r;
   endfunction

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic check_count(input string name);
`ifdef TICK_GEN_COUNT_EN
      check({name, " tick_count"}, 32'(tick_count), 32'(exp_cnt % 4));
`endif
   endtask

   task automatic run_edges(input int n, input string name);
      for (int i = 1; i <= n; i++) begin
         logic exp;
         exp = 1'b0;
         foreach (exp_ticks[j]) if (exp_ticks[j] == i) exp = 1'b1;
         cyc();
         if (exp) exp_cnt++;
         check($sformatf("%s tick@%0d", name, i), 32'(tick), 32'(exp));
         check_count(name);
      end
      exp_ticks.delete();
   endtask

   initial begin
      tbl[0] = mk(1, 0, 0, 0,  0, 1, 0, 0);
      tbl[1] = mk(0, 0, 1, 2,  0, 0, 0, 0);
      tbl[2] = mk(0, 0, 0, 0,  0, 1, 0, 2);
      tbl[3] = mk(1, 0, 1, 1,  0, 1, 0, 0);
      tbl[4] = mk(0, 0, 1, 3,  0, 0, 0, 0);
      tbl[5] = mk(0, 0, 1, 1,  0, 1, 0, 3);
      tbl[6] = mk(0, 0, 0, 0,  0, 1, 0, 3);
      tbl[7] = mk(1, 0, 0, 0,  0, 1, 0, 0);

      // Reset and idle-state handshake vectors
      for (int k = 0; k < 8; k++) begin
         Reset       = tbl[k].rst;
         enable      = tbl[k].en;
         speed_valid = tbl[k].vld;
         speed       = tbl[k].spd;
         cyc();
         if (tbl[k].rst) exp_cnt = 0;
         check($sformatf("vec%0d tick", k), 32'(tick), 32'(tbl[k].tk));
         check($sformatf("vec%0d ready", k),
               32'(speed_ready), 32'(tbl[k].rdy));
         check($sformatf("vec%0d busy", k), 32'(busy), 32'(tbl[k].bsy));
         check($sformatf("vec%0d active", k),
               32'(active_speed), 32'(tbl[k].act));
         check_count($sformatf("vec%0d", k));
      end
      speed_valid = 1'b0;

      // Speed 0: ticks at 10, 20, 30 after the enable edge
      Reset  = 1'b0;
      enable = 1'b1;
      cyc();
      check("t1 busy", 32'(busy), 32'd1);
      check("t1 tick0", 32'(tick), 32'd0);
      exp_ticks = '{10, 20, 30};
      run_edges(30, "t1");

      // Request speed 3 at counter 3
      run_edges(3, "t2 pre");
      speed       = 2'd3;
      speed_valid = 1'b1;
      cyc();
      speed_valid = 1'b0;
      check("t2 ready low", 32'(speed_ready), 32'd0);
      check("t2 accept tick", 32'(tick), 32'd0);
      run_edges(5, "t2 old");
      check("t2 still pending", 32'(speed_ready), 32'd0);
      check("t2 old active", 32'(active_speed), 32'd0);
      exp_ticks = '{1};
      run_edges(1, "t2 wrap");
      check("t2 ready back", 32'(speed_ready), 32'd1);
      check("t2 new active", 32'(active_speed), 32'd3);
      exp_ticks = '{4, 8};
      run_edges(8, "t2 fast");

      // Request accepted on a wrap edge
      run_edges(3, "t3 pre");
      speed       = 2'd1;
      speed_valid = 1'b1;
      exp_ticks   = '{1};
      run_edges(1, "t3 wrap");
      speed_valid = 1'b0;
      check("t3 ready low", 32'(speed_ready), 32'd0);
      check("t3 keep active", 32'(active_speed), 32'd3);
      exp_ticks = '{4};
      run_edges(4, "t3 old");
      check("t3 new active", 32'(active_speed), 32'd1);
      check("t3 ready back", 32'(speed_ready), 32'd1);
      exp_ticks = '{8, 16};
      run_edges(16, "t3 new");

      // Disable at counter 5 with a change pending
      run_edges(4, "t4 pre");
      speed       = 2'd0;
      speed_valid = 1'b1;
      run_edges(1, "t4 req");
      speed_valid = 1'b0;
      check("t4 ready low", 32'(speed_ready), 32'd0);
      enable = 1'b0;
      cyc();
      check("t4 stop tick", 32'(tick), 32'd0);
      check("t4 stop busy", 32'(busy), 32'd0);
      check("t4 stop active", 32'(active_speed), 32'd0);
      check("t4 stop ready", 32'(speed_ready), 32'd1);
      run_edges(3, "t4 idle");
      check("t4 idle busy", 32'(busy), 32'd0);
      enable = 1'b1;
      cyc();
      check("t4 rerun busy", 32'(busy), 32'd1);
      exp_ticks = '{10, 20};
      run_edges(20, "t4 rerun");

      // Reset on what would be a wrap edge, change pending
      run_edges(3, "t5 pre");
      speed       = 2'd2;
      speed_valid = 1'b1;
      cyc();
      speed_valid = 1'b0;
      check("t5 ready low", 32'(speed_ready), 32'd0);
      run_edges(5, "t5 mid");
      Reset = 1'b1;
      cyc();
      exp_cnt = 0;
      check("t5 rst tick", 32'(tick), 32'd0);
      check("t5 rst active", 32'(active_speed), 32'd0);
      check("t5 rst ready", 32'(speed_ready), 32'd1);
      check("t5 rst busy", 32'(busy), 32'd0);
      check_count("t5 rst");
      Reset = 1'b0;
      cyc();
      check("t5 run busy", 32'(busy), 32'd1);
      exp_ticks = '{10};
      run_edges(10, "t5 run");
      check("t5 run active", 32'(active_speed), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
